// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers: FSM state encoding,
// the canonical NOP instruction and the IF/ID packet width.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int          IFID_W    = 96;

endpackage : pipe_pkg

// File: rtl/pipe_skid_reg.sv
// Generic pipeline stage register with a valid/ready handshake, a 2-entry
// skid buffer, flush, and a saturating counter of entries squashed by flush.
// in_ready comes straight from a flop so downstream stall logic never has a
// combinational path back to upstream.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W = IFID_W,
    parameter logic [DATA_W-1:0] BUBBLE = {32'd0, NOP_INSTR, 32'd0},
    parameter int                CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  drop_cnt
);

    pipe_state_e       state_q, state_nx;
    logic [DATA_W-1:0] main_q, main_nx;
    logic [DATA_W-1:0] skid_q, skid_nx;
    logic [CNT_W-1:0]  cnt_q, cnt_nx;
    logic              in_ready_q;
    logic              in_fire, out_fire;
    logic [1:0]        drops;
    logic [CNT_W:0]    cnt_sum;

    // Decode handshake status and occupancy from the current state.
    always_comb begin
        occupancy = 2'd0;
        out_valid = 1'b0;
        case (state_q)
            ST_HALF: begin
                occupancy = 2'd1;
                out_valid = 1'b1;
            end
            ST_FULL: begin
                occupancy = 2'd2;
                out_valid = 1'b1;
            end
            default: begin
                occupancy = 2'd0;
                out_valid = 1'b0;
            end
        endcase
        in_fire  = in_valid & in_ready_q;
        out_fire = out_valid & out_ready;
        // An entry leaving downstream during a flush is not a drop.
        drops    = occupancy - {1'b0, out_fire};
        cnt_sum  = (CNT_W+1)'(cnt_q) + (CNT_W+1)'(drops);
    end

    // Next-state logic: flush squashes everything, otherwise move entries FIFO-style.
    always_comb begin
        state_nx = state_q;
        main_nx  = main_q;
        skid_nx  = skid_q;
        cnt_nx   = cnt_q;
        if (flush) begin
            state_nx = ST_EMPTY;
            main_nx  = BUBBLE;
            skid_nx  = BUBBLE;
            cnt_nx   = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_nx = ST_HALF;
                        main_nx  = in_data;
                    end
                end
                ST_HALF: begin
                    if (in_fire && out_fire) begin
                        main_nx = in_data;
                    end else if (in_fire) begin
                        state_nx = ST_FULL;
                        skid_nx  = in_data;
                    end else if (out_fire) begin
                        state_nx = ST_EMPTY;
                        main_nx  = BUBBLE;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        state_nx = ST_HALF;
                        main_nx  = skid_q;
                        skid_nx  = BUBBLE;
                    end
                end
                default: begin
                    // Unused encoding: fall back to a clean empty stage.
                    state_nx = ST_EMPTY;
                    main_nx  = BUBBLE;
                    skid_nx  = BUBBLE;
                end
            endcase
        end
    end

    // State, data and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            main_q     <= BUBBLE;
            skid_q     <= BUBBLE;
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_nx;
            main_q     <= main_nx;
            skid_q     <= skid_nx;
            cnt_q      <= cnt_nx;
            in_ready_q <= (state_nx != ST_FULL);
        end
    end

    assign in_ready = in_ready_q;
    assign out_data = main_q;
    assign drop_cnt = cnt_q;

endmodule : pipe_skid_reg

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: a queue-based reference model is
// compared every cycle, and directed scenarios add literal expectations.
module tb_pipe_skid_reg;

    localparam int          DATA_W = 96;
    localparam int          CNT_W  = 2;
    localparam logic [95:0] BUB    = {32'd0, 32'h0000_0013, 32'd0};
    localparam int          CMAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  drop_cnt;

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] mq[$];
    int                m_cnt = 0;
    bit                model_on = 1'b0;

    pipe_skid_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [127:0] actual,
                                input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: a FIFO of at most two entries plus a drop counter.
    always @(posedge clk) begin
        bit m_in_fire, m_out_fire;
        int d;
        m_in_fire  = in_valid && (mq.size() < 2);
        m_out_fire = out_ready && (mq.size() > 0);
        if (!rst_n) begin
            mq.delete();
            m_cnt = 0;
        end else if (flush) begin
            d = mq.size() - (m_out_fire ? 1 : 0);
            m_cnt = (m_cnt + d > CMAX) ? CMAX : m_cnt + d;
            mq.delete();
        end else begin
            if (m_out_fire) void'(mq.pop_front());
            if (m_in_fire) mq.push_back(in_data);
        end
        model_on = 1'b1;
    end

    // Compare DUT against the model on every falling edge once reset has been seen.
    always @(negedge clk) begin
        if (model_on) begin
            check_output("m_out_valid", 128'(out_valid), 128'(mq.size() > 0));
            check_output("m_in_ready", 128'(in_ready), 128'(mq.size() < 2));
            check_output("m_occupancy", 128'(occupancy), 128'(mq.size()));
            check_output("m_out_data", 128'(out_data), (mq.size() > 0) ? 128'(mq[0]) : 128'(BUB));
            check_output("m_drop_cnt", 128'(drop_cnt), 128'(m_cnt));
        end
    end

    task automatic apply_stimulus(input logic rn, input logic fl, input logic iv,
                                  input logic [DATA_W-1:0] id, input logic ordy);
        rst_n     = rn;
        flush     = fl;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [DATA_W-1:0] aa;
        aa = {12{8'hAA}};
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // 1. Reset with garbage on the inputs
        apply_stimulus(0, 0, 1, aa, 1);
        apply_stimulus(0, 0, 1, aa, 1);
        check_output("rst_out_valid", 128'(out_valid), 128'd0);
        check_output("rst_in_ready", 128'(in_ready), 128'd1);
        check_output("rst_occ", 128'(occupancy), 128'd0);
        check_output("rst_out_data", 128'(out_data), 128'(BUB));
        check_output("rst_drop", 128'(drop_cnt), 128'd0);

        // 2. Streaming at full throughput
        for (int i = 1; i <= 4; i++) begin
            apply_stimulus(1, 0, 1, DATA_W'(i), 1);
            check_output("stream_data", 128'(out_data), 128'(i));
            check_output("stream_occ", 128'(occupancy), 128'd1);
            check_output("stream_valid", 128'(out_valid), 128'd1);
        end
        apply_stimulus(1, 0, 0, '0, 1);
        check_output("stream_drain_occ", 128'(occupancy), 128'd0);

        // 3. Stall into the skid buffer and release
        apply_stimulus(1, 0, 1, 96'd5, 1);
        check_output("skid_occ1", 128'(occupancy), 128'd1);
        apply_stimulus(1, 0, 1, 96'd6, 0);
        check_output("skid_occ2", 128'(occupancy), 128'd2);
        check_output("skid_in_ready", 128'(in_ready), 128'd0);
        check_output("skid_head", 128'(out_data), 128'd5);
        apply_stimulus(1, 0, 1, 96'd7, 0);
        check_output("skid_hold", 128'(occupancy), 128'd2);
        apply_stimulus(1, 0, 1, 96'd7, 1);
        check_output("skid_rel6", 128'(out_data), 128'd6);
        check_output("skid_rel_occ", 128'(occupancy), 128'd1);
        apply_stimulus(1, 0, 1, 96'd7, 1);
        check_output("skid_rel7", 128'(out_data), 128'd7);
        apply_stimulus(1, 0, 0, '0, 1);
        check_output("skid_empty", 128'(out_data), 128'(BUB));

        // 4. Flush while full, with a new beat offered in the same cycle
        apply_stimulus(1, 0, 1, 96'd8, 0);
        apply_stimulus(1, 0, 1, 96'd9, 0);
        check_output("fl_full_occ", 128'(occupancy), 128'd2);
        apply_stimulus(1, 1, 1, 96'd10, 0);
        check_output("fl_full_valid", 128'(out_valid), 128'd0);
        check_output("fl_full_data", 128'(out_data), 128'(BUB));
        check_output("fl_full_drop", 128'(drop_cnt), 128'd2);
        apply_stimulus(1, 0, 0, '0, 1);
        check_output("fl_no10", 128'(out_valid), 128'd0);

        // 5. Flush while the single entry drains downstream
        apply_stimulus(1, 0, 1, 96'd11, 0);
        check_output("fl_drain_head", 128'(out_data), 128'd11);
        apply_stimulus(1, 1, 0, '0, 1);
        check_output("fl_drain_occ", 128'(occupancy), 128'd0);
        check_output("fl_drain_drop", 128'(drop_cnt), 128'd2);

        // 6. Counter saturation, then reset clears it
        apply_stimulus(0, 0, 0, '0, 0);
        check_output("sat_rst", 128'(drop_cnt), 128'd0);
        for (int k = 0; k < 4; k++) begin
            apply_stimulus(1, 0, 1, DATA_W'(20 + 2 * k), 0);
            apply_stimulus(1, 0, 1, DATA_W'(21 + 2 * k), 0);
            apply_stimulus(1, 1, 0, '0, 0);
            check_output("sat_cnt", 128'(drop_cnt), (k == 0) ? 128'd2 : 128'd3);
        end
        apply_stimulus(0, 0, 0, '0, 0);
        check_output("sat_clear", 128'(drop_cnt), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pipe_skid_reg
